alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 98 +++++++++
 tb/tb_alu_result_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry in-order FIFO that retires results and updates the NZCV flag register.
// Optional macro ALU_RESULT_STAGE_PARITY_EN adds out_parity (XOR-reduction of out_result).
module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_cout,
    input  logic             in_ovf,
    input  logic             in_setflags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
`ifdef ALU_RESULT_STAGE_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             ovf;
        logic             setflags;
    } entry_t;

    entry_t     mem [2];
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    function automatic logic [3:0] calc_nzcv(input entry_t e);
        return {e.result[WIDTH-1], (e.result == '0), e.cout, e.ovf};
    endfunction

    // Readiness depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];

    // Storage is not reset; gating with out_valid keeps out_result at 0 while empty or in reset.
    assign out_result = out_valid ? head.result : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_result, in_cout, in_ovf, in_setflags};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            {flag_n, flag_z, flag_c, flag_v} <= 4'b0000;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            if (pop && head.setflags) begin
                {flag_n, flag_z, flag_c, flag_v} <= calc_nzcv(head);
            end
        end
    end

`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic par_mem [2];

    always_ff @(posedge clk) begin
        if (push) begin
            par_mem[wr_ptr] <= ^in_result;
        end
    end

    assign out_parity = out_valid & par_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table, hand-written corner sequences, scoreboard monitor.
module tb_alu_result_stage;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             in_ovf;
    logic             in_setflags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic             out_parity;
`endif

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .in_ovf     (in_ovf),
        .in_setflags(in_setflags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v)
`ifdef ALU_RESULT_STAGE_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic        cout;
        logic        ovf;
        logic        sf;
        logic [3:0]  nzcv;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic        cout;
        logic        ovf;
        logic        sf;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;
    exp_t sb_q[$];
    logic [3:0] model_flags = 4'b0000;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [63:0] r, input logic c, input logic o, input logic s);
        in_valid    = 1'b1;
        in_result   = r;
        in_cout     = c;
        in_ovf      = o;
        in_setflags = s;
    endtask

    // Scoreboard monitor: sampled on the falling edge, inputs are stable until the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            sb_q.delete();
            model_flags = 4'b0000;
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_in_ready", {63'd0, in_ready}, 64'd1);
            check("rst_out_result", out_result, 64'd0);
        end else begin
            check("mon_out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() > 0});
            check("mon_in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
            check("mon_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, model_flags});
            if (out_valid && out_ready && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                pops++;
                check("mon_out_result", out_result, e.result);
`ifdef ALU_RESULT_STAGE_PARITY_EN
                check("mon_out_parity", {63'd0, out_parity}, {63'd0, ^e.result});
`endif
                if (e.sf) begin
                    model_flags = {e.result[63], e.result == 64'd0, e.cout, e.ovf};
                end
            end
            if (in_valid && in_ready) begin
                e.result = in_result;
                e.cout   = in_cout;
                e.ovf    = in_ovf;
                e.sf     = in_setflags;
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        vecs[0] = '{64'h0000_0000_0000_2084, 1'b1, 1'b0, 1'b1, 4'b0010};
        vecs[1] = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 4'b0100};
        vecs[2] = '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 4'b1001};
        vecs[3] = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 4'b1001};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 4'b1011};
        vecs[5] = '{64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 4'b0000};

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_result   = '0;
        in_cout     = 1'b0;
        in_ovf      = 1'b0;
        in_setflags = 1'b0;
        out_ready   = 1'b0;
        #1;
        check("init_out_valid", {63'd0, out_valid}, 64'd0);
        check("init_in_ready", {63'd0, in_ready}, 64'd1);
        check("init_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        check("init_out_result", out_result, 64'd0);
`ifdef ALU_RESULT_STAGE_PARITY_EN
        check("init_out_parity", {63'd0, out_parity}, 64'd0);
`endif
        @(posedge clk); #2 reset_n = 1'b1;

        // Single push/pop per vector: 1-cycle latency, out_valid for exactly one cycle.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            drive(vecs[i].result, vecs[i].cout, vecs[i].ovf, vecs[i].sf);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("vec_out_valid", {63'd0, out_valid}, 64'd1);
            check("vec_out_result", out_result, vecs[i].result);
`ifdef ALU_RESULT_STAGE_PARITY_EN
            check("vec_out_parity", {63'd0, out_parity}, {63'd0, ^vecs[i].result});
`endif
            @(posedge clk); #1;
            check("vec_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, {60'd0, vecs[i].nzcv});
            check("vec_valid_gone", {63'd0, out_valid}, 64'd0);
        end

        // Backpressure: fill both entries, try a push while full, then drain in order.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(64'h0000_0000_0773_8D92, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(64'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(64'h55, 1'b0, 1'b0, 1'b1);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_head", out_result, 64'h0773_8D92);
        repeat (2) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_result", out_result, 64'h0773_8D92);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_second", out_result, 64'h0);
        check("bp_second_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        check("bp_drained", {63'd0, out_valid}, 64'd0);
        check("bp_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0100);

        // Simultaneous push/pop at occupancy 1 with data 1..10.
        @(posedge clk); #1;
        p0 = pops;
        out_ready = 1'b1;
        drive(64'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk); #1;
            check("sim_head", out_result, 64'(k - 1));
            drive(64'(k), 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sim_last", out_result, 64'd10);
        @(posedge clk); #1;
        check("sim_pop_count", 64'(pops - p0), 64'd10);
        check("sim_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with two entries buffered.
        out_ready = 1'b0;
        drive(64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_full_valid", {63'd0, out_valid}, 64'd1);
        check("mid_full_ready", {63'd0, in_ready}, 64'd0);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);
        check("mid_rst_result", out_result, 64'd0);
        @(posedge clk); #2 reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        check("post_rst_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'd0);

        // First push accepted on the first rising edge after reset release.
        #1 reset_n = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        drive(64'h1234, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_push_valid", {63'd0, out_valid}, 64'd1);
        check("first_push_result", out_result, 64'h1234);
        @(posedge clk); #1;
        check("first_push_flags", {60'd0, flag_n, flag_z, flag_c, flag_v}, 64'b0010);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
